jtcop_obj_dma: RTL and testbench
================================

Name: jtcop_obj_dma

Overview:
- Parametrised object-table DMA and multi-bank buffer: generalised successor of the fixed 1k×16 object buffer.
- CPU writes a shadow table; on a copy trigger the block copies the whole table into a back bank, then promotes that bank to the front for the object draw engine.
- Adds generic width/depth, N-bank rotation, a vblank-gated trigger mode, trigger queuing and a busy/done handshake.
- Sits between the CPU bus decoder and the object draw engine, all in the video clock domain.

Parameters:
- AW, 10, table address width; depth = 2**AW words.
- DW, 16, word width; must be a multiple of 8. Byte lanes BL = DW/8.
- NBANK, 2, engine-side banks, 2..4. Bank index width BW = 1 when NBANK=2, else 2.
- VBONLY, 1: copy may only start while LVBL=0, and bank promotion waits for the next LVBL falling edge. 0: copy starts immediately and promotion is immediate.

Ports:
- clk        in   1      video clock, sole clock
- rst_n      in   1      asynchronous reset, active low
- dma_cen    in   1      DMA step enable; one word per enabled cycle
- LVBL       in   1      vertical blank, low = blanking
- cpu_addr   in   AW     CPU word address into the shadow table
- cpu_dout   in   DW     CPU write data
- cpu_dsn    in   BL     byte strobes, active low
- cpu_rnw    in   1      1 = read
- objram_cs  in   1      shadow table select
- obj_dout   out  DW     CPU read data, 1-cycle latency
- obj_copy   in   1      copy trigger, rising-edge sensitive
- tbl_addr   in   AW     draw-engine read address
- tbl_dout   out  DW     front-bank data, 1-cycle latency
- busy       out  1      high while state is not IDLE or a trigger is queued
- done       out  1      one-clk pulse when a bank is promoted
- front      out  BW     current front bank index

Behaviour:
- Reset is asynchronous. Outputs after reset: state IDLE, front=0, back=1, busy=0, done=0, pend=0, obj_dout=0, tbl_dout=0. RAM contents are not cleared.
- CPU port:
  - Write when objram_cs & ~cpu_rnw, per byte lane with the corresponding cpu_dsn bit low.
  - Reads return the registered word on the next clk.
- Trigger detection:
  - trig = obj_copy & ~obj_copy_l, where obj_copy_l is a registered copy of obj_copy.
  - A trig outside IDLE/WAIT_VB sets pend. Only one trigger is queued; further triggers are dropped.
- FSM:
  - IDLE: on trig or pend, clear pend. Go to COPY if VBONLY=0 or LVBL=0, else to WAIT_VB.
  - WAIT_VB: on LVBL=0, go to COPY with ptr=0. A trig in this state is absorbed (not queued).
  - COPY:
    - On each dma_cen, read shadow[ptr] (1-cycle read, pipelined) and write bank[back][ptr-1].
    - 2**AW+1 enabled cycles are needed per copy. ptr wraps at full count, then go to SWAP.
  - SWAP: if VBONLY=1, wait for the LVBL falling edge; else proceed the same cycle. On promotion:
    - front <= back
    - back <= (back+1) mod NBANK, skipping the new front
    - pulse done
    - go to IDLE
- Collision rules:
  - CPU write to the address being DMA-read in the same cycle: the DMA gets the old data.
  - tbl_addr reads always hit the front bank. front changes only in SWAP, so the draw engine never sees a partial table.
- LVBL rising mid-COPY with VBONLY=1: the copy continues to completion; only the start is gated.
- Reset mid-COPY: the copy is aborted, front returns to 0, and the partial back-bank data is discarded logically.
- dma_cen low stalls the pointer and pipeline with no data loss.

Test Plan:
- Reset release, AW=4, DW=16, NBANK=2, VBONLY=0 -> front=0, busy=0, done=0, tbl_dout=0.
- CPU writes shadow[n]=16'hA500+n for n=0..15, pulses obj_copy, dma_cen=1 -> busy for 17 cycles plus SWAP, a single-cycle done, front=1, tbl_addr=5 returns 16'hA505 one clk later.
- VBONLY=1, trigger while LVBL=1 -> state holds in WAIT_VB. Copy starts the cycle after LVBL falls. Promotion occurs on the following LVBL falling edge, not earlier.
- Second obj_copy during COPY, third also during COPY -> exactly two copies run back to back, two done pulses, busy stays high between them.
- cpu_dsn=2'b10 write of 16'h1234 over 16'hFFFF, then copy -> table word reads 16'hFF34. dma_cen toggling 50% doubles copy time and the data is identical.
- NBANK=3, three completed copies -> front sequence 1, 2, 0. rst_n asserted mid-COPY -> front=0 and busy=0 immediately (asynchronous).

Source files
------------

// File: rtl/jtcop_obj_dma_if.sv
// Bus bundle between the CPU decoder / draw engine side and the object DMA.
// The master side drives the CPU bus, trigger and table address.
// The slave side is the DMA block.
interface jtcop_obj_dma_if #(
  parameter int AW    = 10,
  parameter int DW    = 16,
  parameter int NBANK = 2
);
  localparam int BL = DW / 8;
  localparam int BW = (NBANK == 2) ? 1 : 2;

  logic          dma_cen;
  logic          LVBL;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_dout;
  logic [BL-1:0] cpu_dsn;
  logic          cpu_rnw;
  logic          objram_cs;
  logic [DW-1:0] obj_dout;
  logic          obj_copy;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_dout;
  logic          busy;
  logic          done;
  logic [BW-1:0] front;

  modport master (
    output dma_cen, LVBL, cpu_addr, cpu_dout, cpu_dsn, cpu_rnw, objram_cs,
           obj_copy, tbl_addr,
    input  obj_dout, tbl_dout, busy, done, front
  );

  modport slave (
    input  dma_cen, LVBL, cpu_addr, cpu_dout, cpu_dsn, cpu_rnw, objram_cs,
           obj_copy, tbl_addr,
    output obj_dout, tbl_dout, busy, done, front
  );
endinterface

// File: rtl/jtcop_obj_dma.sv
// Object-table DMA: the CPU fills a shadow table, a copy trigger moves the
// whole table into the back bank, then the back bank is promoted to front
// for the draw engine. The front bank only changes in SWAP, so the engine
// never sees a half-copied table.
//
// state   | meaning
// IDLE    | waiting for a trigger (new or queued)
// WAIT_VB | trigger accepted, waiting for blanking before copying
// COPY    | streaming shadow -> back bank, one word per dma_cen
// SWAP    | copy complete, waiting for promotion point
module jtcop_obj_dma #(
  parameter int AW     = 10,
  parameter int DW     = 16,
  parameter int NBANK  = 2,
  parameter int VBONLY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  jtcop_obj_dma_if.slave bus
);
  localparam int DEPTH = 2**AW;
  localparam int BL    = DW / 8;
  localparam int BW    = (NBANK == 2) ? 1 : 2;
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_VB, COPY, SWAP} state_t;

  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] bank   [NBANK][DEPTH];

  state_t        state;
  logic [AW:0]   ptr;
  logic [BW-1:0] front_r, back;
  logic          pend, done_r, copy_l, lvbl_l;
  logic [DW-1:0] dma_data, obj_dout_r, tbl_dout_r;

  logic          trig, vb_fall, cpu_we, bank_we;
  logic [AW-1:0] wr_addr;

  assign trig    = bus.obj_copy & ~copy_l;
  assign vb_fall = lvbl_l & ~bus.LVBL;
  assign cpu_we  = bus.objram_cs & ~bus.cpu_rnw;
  // ptr runs one ahead of the write address because the shadow read is registered
  assign bank_we = (state == COPY) && bus.dma_cen && (ptr != '0);
  assign wr_addr = ptr[AW-1:0] - AW'(1);

  assign bus.busy     = (state != IDLE) | pend;
  assign bus.done     = done_r;
  assign bus.front    = front_r;
  assign bus.obj_dout = obj_dout_r;
  assign bus.tbl_dout = tbl_dout_r;

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == BW'(NBANK-1)) ? '0 : b + BW'(1);
  endfunction

  // CPU byte-lane writes into the shadow table
  always_ff @(posedge clk) begin
    for (int i = 0; i < BL; i++)
      if (cpu_we && !bus.cpu_dsn[i])
        shadow[bus.cpu_addr][i*8 +: 8] <= bus.cpu_dout[i*8 +: 8];
  end

  // DMA writes of the pipelined shadow word into the back bank
  always_ff @(posedge clk) begin
    if (bank_we) bank[back][wr_addr] <= dma_data;
  end

  // Registered read ports for the CPU and the draw engine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obj_dout_r <= '0;
      tbl_dout_r <= '0;
    end else begin
      if (bus.objram_cs) obj_dout_r <= shadow[bus.cpu_addr];
      tbl_dout_r <= bank[front_r][bus.tbl_addr];
    end
  end

  // Copy sequencer, trigger queue and bank rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      front_r  <= '0;
      back     <= BW'(1);
      pend     <= 1'b0;
      done_r   <= 1'b0;
      copy_l   <= 1'b0;
      lvbl_l   <= 1'b1;
      dma_data <= '0;
    end else begin
      copy_l <= bus.obj_copy;
      lvbl_l <= bus.LVBL;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (trig || pend) begin
            pend  <= 1'b0;
            ptr   <= '0;
            state <= (VBONLY == 0 || !bus.LVBL) ? COPY : WAIT_VB;
          end
        end
        WAIT_VB: begin
          // a second trigger here is redundant with the one already accepted
          if (!bus.LVBL) begin
            ptr   <= '0;
            state <= COPY;
          end
        end
        COPY: begin
          if (trig) pend <= 1'b1;
          if (bus.dma_cen) begin
            dma_data <= shadow[ptr[AW-1:0]];
            if (ptr == LAST) begin
              ptr   <= '0;
              state <= SWAP;
            end else begin
              ptr <= ptr + (AW+1)'(1);
            end
          end
        end
        SWAP: begin
          if (trig) pend <= 1'b1;
          if (VBONLY == 0 || vb_fall) begin
            front_r <= back;
            back    <= next_bank(back);
            done_r  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Bench for jtcop_obj_dma: three instances (NBANK=2 immediate, NBANK=2
// blanking-gated, NBANK=3 immediate) share the CPU bus and table address;
// each has its own copy trigger. A table-level model tracks the shadow
// contents and, per instance, the table snapshot and number of promotions.
module tb_jtcop_obj_dma;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cen = 1'b0, lvbl = 1'b1, cs = 1'b0, rnw = 1'b1;
  logic        copy0 = 1'b0, copy1 = 1'b0, copy2 = 1'b0;
  logic [3:0]  addr = '0, taddr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  dsn = 2'b11;

  jtcop_obj_dma_if #(.AW(4), .DW(16), .NBANK(2)) if0 ();
  jtcop_obj_dma_if #(.AW(4), .DW(16), .NBANK(2)) if1 ();
  jtcop_obj_dma_if #(.AW(4), .DW(16), .NBANK(3)) if2 ();

  assign if0.dma_cen = cen;   assign if1.dma_cen = cen;   assign if2.dma_cen = cen;
  assign if0.LVBL = lvbl;     assign if1.LVBL = lvbl;     assign if2.LVBL = lvbl;
  assign if0.cpu_addr = addr; assign if1.cpu_addr = addr; assign if2.cpu_addr = addr;
  assign if0.cpu_dout = wdata; assign if1.cpu_dout = wdata; assign if2.cpu_dout = wdata;
  assign if0.cpu_dsn = dsn;   assign if1.cpu_dsn = dsn;   assign if2.cpu_dsn = dsn;
  assign if0.cpu_rnw = rnw;   assign if1.cpu_rnw = rnw;   assign if2.cpu_rnw = rnw;
  assign if0.objram_cs = cs;  assign if1.objram_cs = cs;  assign if2.objram_cs = cs;
  assign if0.tbl_addr = taddr; assign if1.tbl_addr = taddr; assign if2.tbl_addr = taddr;
  assign if0.obj_copy = copy0; assign if1.obj_copy = copy1; assign if2.obj_copy = copy2;

  jtcop_obj_dma #(.AW(4), .DW(16), .NBANK(2), .VBONLY(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  jtcop_obj_dma #(.AW(4), .DW(16), .NBANK(2), .VBONLY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  jtcop_obj_dma #(.AW(4), .DW(16), .NBANK(3), .VBONLY(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int passes = 0;
  int total  = 0;

  logic [15:0] shadow_m [16];
  logic [15:0] exp_tbl  [3][16];
  int          ncopy    [3];
  int          nbank    [3] = '{2, 2, 3};

  // sel: 0 busy, 1 done, 2 front, 3 tbl_dout, 4 obj_dout
  function automatic logic [31:0] dut(input int w, input int sel);
    logic [31:0] r;
    r = '0;
    case (w)
      0: case (sel) 0: r = 32'(if0.busy); 1: r = 32'(if0.done); 2: r = 32'(if0.front);
                    3: r = 32'(if0.tbl_dout); default: r = 32'(if0.obj_dout); endcase
      1: case (sel) 0: r = 32'(if1.busy); 1: r = 32'(if1.done); 2: r = 32'(if1.front);
                    3: r = 32'(if1.tbl_dout); default: r = 32'(if1.obj_dout); endcase
      default: case (sel) 0: r = 32'(if2.busy); 1: r = 32'(if2.done); 2: r = 32'(if2.front);
                    3: r = 32'(if2.tbl_dout); default: r = 32'(if2.obj_dout); endcase
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_copy(input int w, input logic v);
    case (w)
      0: copy0 = v;
      1: copy1 = v;
      default: copy2 = v;
    endcase
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    @(posedge clk); #1;
    addr = a; wdata = d; dsn = m; rnw = 1'b0; cs = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; rnw = 1'b1; dsn = 2'b11;
    for (int l = 0; l < 2; l++)
      if (!m[l]) shadow_m[a][l*8 +: 8] = d[l*8 +: 8];
  endtask

  task automatic cpu_rd_chk(input logic [3:0] a);
    @(posedge clk); #1;
    addr = a; rnw = 1'b1; cs = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0;
    @(negedge clk);
    chk($sformatf("obj_dout[%0d]", a), dut(0, 4), 32'(shadow_m[a]));
  endtask

  task automatic tbl_chk_all(input int w);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      taddr = 4'(i);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("u%0d tbl[%0d]", w, i), dut(w, 3), 32'(exp_tbl[w][i]));
    end
  endtask

  // Fire one trigger on instance w and follow it until busy drops.
  // extra: two more trigger pulses while the copy runs; toggle: 50% dma_cen.
  task automatic run_copy(input int w, input bit extra, input bit toggle,
                          output int bcyc, output int dcnt);
    bit expired;
    expired = 1'b1;
    bcyc = 0;
    dcnt = 0;
    @(posedge clk); #1 set_copy(w, 1'b1);
    @(posedge clk); #1 set_copy(w, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dut(w, 1) == 1) dcnt++;
      if (dut(w, 0) == 0) begin
        expired = 1'b0;
        break;
      end
      bcyc++;
      set_copy(w, extra && (i == 4 || i == 9));
      if (toggle) cen = ~cen;
    end
    set_copy(w, 1'b0);
    cen = 1'b1;
    chk($sformatf("u%0d copy finished in time", w), 32'(expired), 32'd0);
    ncopy[w] += dcnt;
    exp_tbl[w] = shadow_m;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, d, dc;
    logic [3:0] ra;
    int fseq [3] = '{1, 2, 0};

    for (int w = 0; w < 3; w++) ncopy[w] = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("u%0d reset busy", w), dut(w, 0), 32'd0);
      chk($sformatf("u%0d reset done", w), dut(w, 1), 32'd0);
      chk($sformatf("u%0d reset front", w), dut(w, 2), 32'd0);
      chk($sformatf("u%0d reset tbl_dout", w), dut(w, 3), 32'd0);
    end
    chk("reset obj_dout", dut(0, 4), 32'd0);

    // basic copy, immediate mode
    for (int n = 0; n < 16; n++) cpu_wr(4'(n), 16'hA500 + 16'(n), 2'b00);
    cpu_rd_chk(4'd3);
    cen = 1'b1;
    run_copy(0, 1'b0, 1'b0, b, d);
    chk("u0 busy cycles", 32'(b), 32'd18);
    chk("u0 done pulses", 32'(d), 32'd1);
    chk("u0 front after copy", dut(0, 2), 32'(ncopy[0] % nbank[0]));
    @(posedge clk); #1 taddr = 4'd5;
    @(posedge clk); @(negedge clk);
    chk("u0 tbl[5] literal", dut(0, 3), 32'h0000A505);
    tbl_chk_all(0);

    // blanking-gated instance
    lvbl = 1'b1;
    @(posedge clk); #1 copy1 = 1'b1;
    @(posedge clk); #1 copy1 = 1'b0;
    dc = 0;
    repeat (30) begin @(negedge clk); if (if1.done) dc++; end
    chk("u1 waits busy", dut(1, 0), 32'd1);
    chk("u1 waits front", dut(1, 2), 32'd0);
    @(posedge clk); #1 copy1 = 1'b1;
    @(posedge clk); #1 copy1 = 1'b0;
    @(negedge clk); lvbl = 1'b0;
    repeat (25) begin @(negedge clk); if (if1.done) dc++; end
    chk("u1 no early done", 32'(dc), 32'd0);
    chk("u1 no early front", dut(1, 2), 32'd0);
    chk("u1 busy in swap", dut(1, 0), 32'd1);
    lvbl = 1'b1;
    repeat (5) @(negedge clk);
    chk("u1 no promote on rise", dut(1, 2), 32'd0);
    lvbl = 1'b0;
    @(negedge clk);
    chk("u1 done on fall", dut(1, 1), 32'd1);
    chk("u1 front on fall", dut(1, 2), 32'd1);
    chk("u1 idle after promote", dut(1, 0), 32'd0);
    @(negedge clk);
    chk("u1 done single cycle", dut(1, 1), 32'd0);
    chk("u1 absorbed trigger", dut(1, 0), 32'd0);
    lvbl = 1'b1;
    ncopy[1] = 1;
    exp_tbl[1] = shadow_m;
    tbl_chk_all(1);

    // trigger queuing: three triggers -> two back-to-back copies
    run_copy(0, 1'b1, 1'b0, b, d);
    chk("u0 queued busy cycles", 32'(b), 32'd37);
    chk("u0 queued done pulses", 32'(d), 32'd2);
    chk("u0 front after queue", dut(0, 2), 32'(ncopy[0] % nbank[0]));

    // byte strobes, random writes, half-rate DMA
    cpu_wr(4'd7, 16'hFFFF, 2'b00);
    cpu_wr(4'd7, 16'h1234, 2'b10);
    cpu_rd_chk(4'd7);
    for (int k = 0; k < 12; k++) begin
      ra = 4'($urandom_range(0, 15));
      if (ra == 4'd7) ra = 4'd6;
      cpu_wr(ra, 16'($urandom), 2'($urandom_range(0, 3)));
    end
    run_copy(0, 1'b0, 1'b1, b, d);
    chk("u0 half-rate busy cycles", 32'(b), 32'd35);
    chk("u0 half-rate done", 32'(d), 32'd1);
    chk("u0 front half-rate", dut(0, 2), 32'(ncopy[0] % nbank[0]));
    @(posedge clk); #1 taddr = 4'd7;
    @(posedge clk); @(negedge clk);
    chk("u0 tbl[7] byte merge", dut(0, 3), 32'h0000FF34);
    tbl_chk_all(0);

    // three-bank rotation
    for (int k = 0; k < 3; k++) begin
      run_copy(2, 1'b0, 1'b0, b, d);
      chk($sformatf("u2 rotation %0d", k), dut(2, 2), 32'(fseq[k]));
    end
    tbl_chk_all(2);
    for (int k = 0; k < 8; k++)
      cpu_wr(4'($urandom_range(0, 15)), 16'($urandom), 2'b00);
    run_copy(2, 1'b0, 1'b0, b, d);
    chk("u2 front 4th copy", dut(2, 2), 32'(ncopy[2] % nbank[2]));
    tbl_chk_all(2);

    // asynchronous reset in the middle of a copy
    @(posedge clk); #1 copy2 = 1'b1;
    @(posedge clk); #1 copy2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("u2 busy before reset", dut(2, 0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("u2 front at reset", dut(2, 2), 32'd0);
    chk("u2 busy at reset", dut(2, 0), 32'd0);
    chk("u2 tbl_dout at reset", dut(2, 3), 32'd0);
    for (int w = 0; w < 3; w++) ncopy[w] = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_copy(2, 1'b0, 1'b0, b, d);
    chk("u2 front after reset copy", dut(2, 2), 32'(ncopy[2] % nbank[2]));
    tbl_chk_all(2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
